// File: rtl/rom_fetch_ctrl_if.sv
// rtl/rom_fetch_ctrl_if.sv - request/response and ROM-side signals of the shared ROM fetch controller
interface rom_fetch_ctrl_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
);
  logic               if_req;
  logic [A_WIDTH-1:0] if_addr;
  logic               if_valid;
  logic [31:0]        if_rdata;
  logic               ld_req;
  logic [A_WIDTH-1:0] ld_addr;
  logic               ld_valid;
  logic [31:0]        ld_rdata;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_rd;
  logic               busy;

  // Requesters and the ROM together form the environment side.
  modport master (
    output if_req, if_addr, ld_req, ld_addr, mem_rd,
    input  if_valid, if_rdata, ld_valid, ld_rdata, mem_addr, busy
  );

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, mem_rd,
    output if_valid, if_rdata, ld_valid, ld_rdata, mem_addr, busy
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - round-robin arbiter assembling big-endian 32-bit words from a byte-wide ROM
module rom_fetch_ctrl #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  rom_fetch_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t             state;
  logic               gnt_ld;
  logic               last_ld;
  logic [A_WIDTH-1:0] base;
  logic [1:0]         cnt;
  logic [1:0]         cnt_nxt;
  logic [23:0]        word;
  logic               pick_ld;
  logic [7:0]         rd_byte;

  // Load wins only when fetch is idle or fetch was the last grant.
  assign pick_ld = bus.ld_req && (!bus.if_req || !last_ld);
  assign cnt_nxt = cnt + 2'd1;
  assign rd_byte = bus.mem_rd[D_WIDTH-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gnt_ld       <= 1'b0;
      last_ld      <= 1'b1;
      base         <= '0;
      cnt          <= 2'd0;
      word         <= 24'd0;
      bus.mem_addr <= '0;
      bus.if_valid <= 1'b0;
      bus.ld_valid <= 1'b0;
      bus.if_rdata <= 32'd0;
      bus.ld_rdata <= 32'd0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.ld_req) begin
            gnt_ld       <= pick_ld;
            last_ld      <= pick_ld;
            base         <= pick_ld ? bus.ld_addr : bus.if_addr;
            bus.mem_addr <= pick_ld ? bus.ld_addr : bus.if_addr;
            cnt          <= 2'd0;
            bus.busy     <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          word <= {word[15:0], rd_byte};
          cnt  <= cnt_nxt;
          if (cnt == 2'd3) begin
            state <= DONE;
            if (gnt_ld) begin
              bus.ld_valid <= 1'b1;
              bus.ld_rdata <= {word, rd_byte};
            end else begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= {word, rd_byte};
            end
          end else begin
            // Address arithmetic wraps naturally at A_WIDTH bits.
            bus.mem_addr <= base + A_WIDTH'(cnt_nxt);
          end
        end
        DONE: begin
          bus.if_valid <= 1'b0;
          bus.ld_valid <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb/tb_rom_fetch_ctrl.sv - directed bench for rom_fetch_ctrl with an identity byte ROM
module tb_rom_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   pulses;

  always #5 clk = ~clk;

  rom_fetch_ctrl_if #(.A_WIDTH(12), .D_WIDTH(8)) bus ();
  assign bus.mem_rd = bus.mem_addr[7:0];

  rom_fetch_ctrl #(.A_WIDTH(12), .D_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0;
    step(); step();
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_ld_rdata", bus.ld_rdata, 32'h0);
    rst = 1'b0;
    step();

    // basic fetch at 0x010
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    check("t1_busy_c0", 32'(bus.busy), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) bus.if_req = 1'b0;
      check($sformatf("t1_mem_addr_c%0d", k), 32'(bus.mem_addr), 32'h010 + 32'(k - 1));
      check($sformatf("t1_busy_c%0d", k), 32'(bus.busy), 32'd1);
      check($sformatf("t1_if_valid_c%0d", k), 32'(bus.if_valid), 32'd0);
    end
    step();
    check("t1_if_valid_c5", 32'(bus.if_valid), 32'd1);
    check("t1_if_rdata_c5", bus.if_rdata, 32'h10111213);
    check("t1_busy_c5", 32'(bus.busy), 32'd1);
    check("t1_ld_valid_c5", 32'(bus.ld_valid), 32'd0);
    step();
    check("t1_if_valid_c6", 32'(bus.if_valid), 32'd0);
    check("t1_busy_c6", 32'(bus.busy), 32'd0);
    check("t1_mem_addr_hold", 32'(bus.mem_addr), 32'h013);
    check("t1_if_rdata_hold", bus.if_rdata, 32'h10111213);

    // load wrapping past the top of the ROM
    bus.ld_req = 1'b1; bus.ld_addr = 12'hFFE;
    step(); bus.ld_req = 1'b0;
    check("t2_mem_addr_c1", 32'(bus.mem_addr), 32'hFFE);
    step(); check("t2_mem_addr_c2", 32'(bus.mem_addr), 32'hFFF);
    step(); check("t2_mem_addr_c3", 32'(bus.mem_addr), 32'h000);
    step(); check("t2_mem_addr_c4", 32'(bus.mem_addr), 32'h001);
    step();
    check("t2_ld_valid_c5", 32'(bus.ld_valid), 32'd1);
    check("t2_ld_rdata_c5", bus.ld_rdata, 32'hFEFF0001);
    check("t2_if_valid_c5", 32'(bus.if_valid), 32'd0);
    check("t2_if_rdata_kept", bus.if_rdata, 32'h10111213);
    step();

    // tie after reset: fetch first, then load, then fetch again
    rst = 1'b1;
    #1;
    check("t3_rst_if_rdata", bus.if_rdata, 32'h0);
    check("t3_rst_ld_rdata", bus.ld_rdata, 32'h0);
    step();
    rst = 1'b0;
    step();
    bus.if_req = 1'b1; bus.if_addr = 12'h020;
    bus.ld_req = 1'b1; bus.ld_addr = 12'h040;
    step(); check("t3_mem_addr_c1", 32'(bus.mem_addr), 32'h020);
    step(); step(); step(); step();
    check("t3_if_valid_c5", 32'(bus.if_valid), 32'd1);
    check("t3_if_rdata_c5", bus.if_rdata, 32'h20212223);
    check("t3_ld_valid_c5", 32'(bus.ld_valid), 32'd0);
    step();
    check("t3_busy_c6", 32'(bus.busy), 32'd0);
    step(); check("t3_mem_addr_c7", 32'(bus.mem_addr), 32'h040);
    step(); step(); step(); step();
    check("t3_ld_valid_c11", 32'(bus.ld_valid), 32'd1);
    check("t3_ld_rdata_c11", bus.ld_rdata, 32'h40414243);
    check("t3_if_valid_c11", 32'(bus.if_valid), 32'd0);
    step(); step();
    check("t3_regrant_fetch_c13", 32'(bus.mem_addr), 32'h020);
    bus.if_req = 1'b0; bus.ld_req = 1'b0;
    step(); step(); step(); step();
    check("t3_if_valid_c17", 32'(bus.if_valid), 32'd1);
    check("t3_ld_rdata_kept", bus.ld_rdata, 32'h40414243);
    step();

    // reset mid-transaction
    bus.if_req = 1'b1; bus.if_addr = 12'h030;
    step(); bus.if_req = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(bus.busy), 32'd0);
    check("t4_rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("t4_rst_if_rdata", bus.if_rdata, 32'h0);
    check("t4_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    step();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.if_valid === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    check("t4_no_activity", 32'(pulses), 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 12'h0A0;
    step(); bus.if_req = 1'b0;
    step(); step(); step(); step();
    check("t4_if_valid_c5", 32'(bus.if_valid), 32'd1);
    check("t4_if_rdata_c5", bus.if_rdata, 32'hA0A1A2A3);
    step();

    // unaligned one-cycle request, address changed mid-read
    bus.if_req = 1'b1; bus.if_addr = 12'h005;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) bus.if_req = 1'b0;
      if (k == 2) bus.if_addr = 12'h100;
      if (bus.if_valid === 1'b1) pulses++;
      if (k == 5) begin
        check("t5_if_valid_c5", 32'(bus.if_valid), 32'd1);
        check("t5_if_rdata_c5", bus.if_rdata, 32'h05060708);
      end
    end
    check("t5_pulse_count", 32'(pulses), 32'd1);
    check("t5_ld_rdata_kept", bus.ld_rdata, 32'h0);
    check("t5_if_rdata_hold", bus.if_rdata, 32'h05060708);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter A_WIDTH, default 12, meaning byte-address width of the shared instruction ROM (4096 bytes).
REQ-002 SHALL have parameter D_WIDTH, default 8, meaning ROM data width (one byte per read).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_req  input  1  instruction-fetch requester asks for a 32-bit word.
REQ-006 SHALL have port if_addr  input  A_WIDTH  fetch byte address (ROM-relative, offset already removed).
REQ-007 SHALL have port if_valid  output  1  one-cycle pulse, fetch word available.
REQ-008 SHALL have port if_rdata  output  32  fetch word.
REQ-009 SHALL have port ld_req  input  1  data-side load requester asks for a 32-bit ROM word.
REQ-010 SHALL have port ld_addr  input  A_WIDTH  load byte address.
REQ-011 SHALL have port ld_valid  output  1  one-cycle pulse, load word available.
REQ-012 SHALL have port ld_rdata  output  32  load word.
REQ-013 SHALL have port mem_addr  output  A_WIDTH  byte address driven to the ROM.
REQ-014 SHALL have port mem_rd  input  D_WIDTH  ROM byte, combinational from mem_addr.
REQ-015 SHALL have port busy  output  1  high while a transaction is in progress (states READ, DONE).

Function
REQ-016 SHALL implement FSM states IDLE, READ, DONE.
REQ-017 In IDLE with any req high, SHALL grant one requester, latch its address as base, clear byte counter cnt, go to READ.
REQ-018 Arbitration SHALL be round-robin: if both req high, grant the requester not granted last; if one high, grant it.
REQ-019 Round-robin pointer SHALL reset to "last = load", so fetch wins the first tie.
REQ-020 In READ, SHALL drive mem_addr = base + cnt, modulo 2^A_WIDTH (wrap 0xFFF -> 0x000).
REQ-021 In READ, each cycle SHALL capture mem_rd big-endian: byte at base into bits 31:24, base+1 into 23:16, base+2 into 15:8, base+3 into 7:0.
REQ-022 cnt SHALL be 2 bits, increment each READ cycle; after capture at cnt=3 go to DONE.
REQ-023 In DONE, SHALL assert the granted port's valid for exactly one cycle with the assembled word on its rdata, then go to IDLE.
REQ-024 Latency SHALL be 5 cycles: req sampled in IDLE at cycle 0, bytes in cycles 1-4, valid in cycle 5; throughput one word per 6 cycles.
REQ-025 if_rdata/ld_rdata SHALL hold their last delivered word until that port's next valid; the non-granted port's rdata SHALL not change.
REQ-026 Addresses SHALL NOT require alignment; any byte address is legal.
REQ-027 Address and req changes during READ/DONE SHALL be ignored; req is re-sampled only in IDLE.
REQ-028 A requester holding req through its valid cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-029 In IDLE, mem_addr SHALL hold its last value (0 after reset).
REQ-030 busy SHALL be low in IDLE, high in READ and DONE.

Reset
REQ-031 On rst high, SHALL immediately force state IDLE, cnt 0, base 0, mem_addr 0, if_valid 0, ld_valid 0, if_rdata 0, ld_rdata 0, busy 0, pointer "last = load".
REQ-032 rst asserted mid-transaction SHALL abort it with no valid pulse; the first request after rst deassertion is sampled on the next rising edge in IDLE.

Verification
REQ-033 ROM model mem[i] = i[7:0]; if_req=1, if_addr=0x010 at cycle 0 -> mem_addr 0x010..0x013 cycles 1-4, if_valid=1 and if_rdata=0x10111213 at cycle 5, busy 1 cycles 1-5.
REQ-034 Wrap: ld_req, ld_addr=0xFFE -> mem_addr 0xFFE,0xFFF,0x000,0x001; ld_rdata=0xFEFF0001, ld_valid at cycle 5.
REQ-035 Tie after reset: if_req=ld_req=1 held, if_addr=0x020, ld_addr=0x040 -> if_valid cycle 5 (0x20212223), ld_valid cycle 11 (0x40414243), next grant to fetch again.
REQ-036 Reset mid-op: if_req at cycle 0, rst pulse during cycle 3 -> no if_valid, busy 0, if_rdata 0; new request after rst completes normally in 5 cycles.
REQ-037 Unaligned and req drop: if_addr=0x005 pulsed for one cycle, if_addr changed to 0x100 in cycle 2 -> if_rdata=0x05060708, exactly one if_valid pulse, ld_rdata unchanged.
